local_history_unit: RTL and testbench
=====================================

LOCAL_HISTORY_UNIT -- requirements
Module: local_history_unit

Interface
REQ-001 SHALL have parameter ENTRIES, default 1024, number of history entries; power of two, >= 2.
REQ-002 SHALL have parameter HIST_W, default 10, history bits per entry.
REQ-003 SHALL have parameter PC_W, default 32, PC width.
REQ-004 SHALL have parameter IDX_LSB, default 0, lowest PC bit used for the index; IDX_W = clog2(ENTRIES), index = pc[IDX_LSB +: IDX_W].
REQ-005 SHALL have port clock, input, 1, the single clock; all state on rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port flush, input, 1, request to clear all histories.
REQ-008 SHALL have port lookup_pc, input, PC_W, PC being predicted.
REQ-009 SHALL have port hist_out, output, HIST_W, history for lookup_pc.
REQ-010 SHALL have port upd_valid, input, 1, resolved-branch update strobe.
REQ-011 SHALL have port upd_pc, input, PC_W, PC of the resolved branch.
REQ-012 SHALL have port upd_taken, input, 1, resolved direction.
REQ-013 SHALL have port ready, output, 1, table initialised and accepting updates.

Function
REQ-014 SHALL implement a two-state FSM, CLEAR and RUN, with an IDX_W-bit clear counter.
REQ-015 SHALL, in CLEAR, write zero to entry[counter] each cycle and then increment the counter.
REQ-016 SHALL go from CLEAR to RUN on the cycle the entry ENTRIES-1 is written, so a clear lasts exactly ENTRIES cycles.
REQ-017 SHALL drive ready = 1 only in RUN; ready rises on the first edge after the final clear write.
REQ-018 SHALL drive hist_out to zero in CLEAR.
REQ-019 SHALL drive hist_out combinationally in RUN as entry[index(lookup_pc)], with zero latency.
REQ-020 SHALL, in RUN with upd_valid=1, write entry[index(upd_pc)] <= {upd_taken, old[HIST_W-1:1]} at the rising edge, shifting the newest outcome into the MSB and dropping the LSB.
REQ-021 SHALL forward the update: when upd_valid=1 in RUN and index(lookup_pc)==index(upd_pc) in the same cycle, hist_out equals the post-update value.
REQ-022 SHALL ignore upd_valid in CLEAR, with no write and no later effect.
REQ-023 SHALL, on flush=1 in RUN, enter CLEAR with counter=0 on the next edge; an update in the same cycle is dropped.
REQ-024 SHALL, on flush=1 in CLEAR, restart the counter at 0.
REQ-025 SHALL ignore PC bits outside the index field; aliasing PCs share one entry.
REQ-026 SHALL, when HIST_W==1, store upd_taken directly.

Reset
REQ-027 SHALL, while reset=0, asynchronously force state=CLEAR, counter=0, ready=0 and hist_out=0.
REQ-028 SHALL NOT asynchronously reset the array itself; array contents are cleared only by the CLEAR sweep.
REQ-029 SHALL, on reset asserted mid-sweep or in RUN, restart a full ENTRIES-cycle sweep after deassertion.

Structure
REQ-030 SHALL declare the FSM state enum (CLEAR, RUN) and the default parameter values in shared package lhu_pkg.
REQ-031 SHALL implement the sweep counter and FSM as one sub-module, lhu_clear_seq, outputting clr_active, clr_idx and ready; the top level holds the array, index extraction and forwarding.
REQ-032 SHALL be synthesisable with no initial blocks.

Verification
REQ-033 SHALL cover: reset low 2 cycles then high -> ready=0 for exactly 1024 cycles, then 1; hist_out=0 throughout.
REQ-034 SHALL cover: in RUN, upd_pc=1234 updated taken,taken,not-taken over 3 cycles -> lookup 1234 returns 10'b0110000000.
REQ-035 SHALL cover: same cycle upd_valid=1, upd_pc=lookup_pc=5, taken=1, entry 0 -> hist_out=10'b1000000000 that cycle.
REQ-036 SHALL cover: upd_pc=1234 vs 1234+1024 (aliases) -> one update is visible at both PCs; IDX_LSB=2 with PCs 0x10 and 0x11 -> the same entry.
REQ-037 SHALL cover: flush pulse with upd_valid=1 -> update dropped, ready=0 next cycle for 1024 cycles, all entries read 0 afterwards.
REQ-038 SHALL cover: reset asserted at sweep cycle 500, plus updates during CLEAR -> the full sweep restarts and no update lands; repeat with ENTRIES=16, HIST_W=4.

Source files
------------

// File: rtl/lhu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lhu_pkg
// Description : Shared state encoding and default sizes for the local
//               branch-history unit.
// Revision    : 1.0 - initial release
// ============================================================================
package lhu_pkg;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } lhu_state_t;

  localparam int c_DEF_ENTRIES = 1024;
  localparam int c_DEF_HIST_W  = 10;
  localparam int c_DEF_PC_W    = 32;
  localparam int c_DEF_IDX_LSB = 0;

endpackage
`default_nettype wire

// File: rtl/lhu_clear_seq.sv
`default_nettype none
// ============================================================================
// Module      : lhu_clear_seq
// Description : Sweep counter and CLEAR/RUN sequencer that walks every
//               history entry to zero before the table is declared ready.
// Revision    : 1.0 - initial release
// ============================================================================
module lhu_clear_seq #(
  parameter int ENTRIES = lhu_pkg::c_DEF_ENTRIES,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  output logic             clr_active,
  output logic [IDX_W-1:0] clr_idx,
  output logic             ready
);
  import lhu_pkg::*;

  localparam logic [IDX_W-1:0] c_LAST = IDX_W'(ENTRIES - 1);

  lhu_state_t       r_state;
  lhu_state_t       w_state_nxt;
  logic [IDX_W-1:0] r_cnt;
  logic [IDX_W-1:0] w_cnt_nxt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    clr_active  = 1'b0;
    ready       = 1'b0;
    case (r_state)
      CLEAR: begin
        clr_active = 1'b1;
        if (flush) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == c_LAST) begin
          // The final zero write happens on this edge, so RUN follows directly.
          w_state_nxt = RUN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      RUN: begin
        ready = 1'b1;
        if (flush) begin
          w_state_nxt = CLEAR;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = CLEAR;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign clr_idx = r_cnt;

endmodule
`default_nettype wire

// File: rtl/local_history_unit.sv
`default_nettype none
// ============================================================================
// Module      : local_history_unit
// Description : Per-PC local branch-history table with sweep clear,
//               shift-in updates and same-cycle update forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
module local_history_unit #(
  parameter int ENTRIES = lhu_pkg::c_DEF_ENTRIES,
  parameter int HIST_W  = lhu_pkg::c_DEF_HIST_W,
  parameter int PC_W    = lhu_pkg::c_DEF_PC_W,
  parameter int IDX_LSB = lhu_pkg::c_DEF_IDX_LSB
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic [PC_W-1:0]   lookup_pc,
  output logic [HIST_W-1:0] hist_out,
  input  logic              upd_valid,
  input  logic [PC_W-1:0]   upd_pc,
  input  logic              upd_taken,
  output logic              ready
);
  import lhu_pkg::*;

  localparam int c_IDX_W = $clog2(ENTRIES);

  // Deliberately no reset on the storage; only the sweep clears it.
  logic [HIST_W-1:0]  r_mem [ENTRIES];

  logic               w_clr_active;
  logic [c_IDX_W-1:0] w_clr_idx;
  logic [c_IDX_W-1:0] w_lk_idx;
  logic [c_IDX_W-1:0] w_up_idx;
  logic               w_upd_fire;
  logic [HIST_W-1:0]  w_upd_old;
  logic [HIST_W-1:0]  w_upd_hist;
  logic               w_we;
  logic [c_IDX_W-1:0] w_waddr;
  logic [HIST_W-1:0]  w_wdata;
  logic               w_unused;

  lhu_clear_seq #(
    .ENTRIES (ENTRIES),
    .IDX_W   (c_IDX_W)
  ) u_clear_seq (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush),
    .clr_active (w_clr_active),
    .clr_idx    (w_clr_idx),
    .ready      (ready)
  );

  assign w_lk_idx   = lookup_pc[IDX_LSB +: c_IDX_W];
  assign w_up_idx   = upd_pc[IDX_LSB +: c_IDX_W];
  // A flush in RUN discards any update presented alongside it.
  assign w_upd_fire = upd_valid && !w_clr_active && !flush;
  assign w_upd_old  = r_mem[w_up_idx];

  generate
    if (HIST_W == 1) begin : g_hist1
      assign w_upd_hist = upd_taken;
    end else begin : g_histn
      assign w_upd_hist = {upd_taken, w_upd_old[HIST_W-1:1]};
    end
  endgenerate

  assign w_we    = w_clr_active || w_upd_fire;
  assign w_waddr = w_clr_active ? w_clr_idx : w_up_idx;
  assign w_wdata = w_clr_active ? '0 : w_upd_hist;

  always_ff @(posedge clock) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  always_comb begin
    hist_out = '0;
    if (!w_clr_active) begin
      if (w_upd_fire && (w_lk_idx == w_up_idx)) begin
        hist_out = w_upd_hist;
      end else begin
        hist_out = r_mem[w_lk_idx];
      end
    end
  end

  // PC bits outside the index field and the dropped history bit are unused.
  assign w_unused = ^{lookup_pc, upd_pc, w_upd_old};

endmodule
`default_nettype wire

// File: tb/tb_local_history_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_local_history_unit
// Description : Self-checking bench; two configurations against a table model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_local_history_unit;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        a_reset, a_flush, a_uv, a_ut, a_ready;
  logic [31:0] a_lk, a_up;
  logic [9:0]  a_hist;
  logic        b_reset, b_flush, b_uv, b_ut, b_ready;
  logic [31:0] b_lk, b_up;
  logic [3:0]  b_hist;

  local_history_unit #(.ENTRIES(1024), .HIST_W(10), .PC_W(32), .IDX_LSB(0)) dut_a (
    .clock(clock), .reset(a_reset), .flush(a_flush), .lookup_pc(a_lk),
    .hist_out(a_hist), .upd_valid(a_uv), .upd_pc(a_up), .upd_taken(a_ut),
    .ready(a_ready));

  local_history_unit #(.ENTRIES(16), .HIST_W(4), .PC_W(32), .IDX_LSB(2)) dut_b (
    .clock(clock), .reset(b_reset), .flush(b_flush), .lookup_pc(b_lk),
    .hist_out(b_hist), .upd_valid(b_uv), .upd_pc(b_up), .upd_taken(b_ut),
    .ready(b_ready));

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  // Model: cycles of clearing still owed, plus the visible table contents.
  int          ent [2] = '{1024, 16};
  int          hw  [2] = '{10, 4};
  int          lsb [2] = '{0, 2};
  int          m_left [2] = '{0, 0};
  int unsigned mem [2][1024];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int idx(int x, logic [31:0] pc);
    return int'((pc >> lsb[x]) % 32'(ent[x]));
  endfunction

  function automatic int unsigned push(int x, int unsigned old, logic t);
    return (32'(t) << (hw[x] - 1)) | (old >> 1);
  endfunction

  function automatic logic [31:0] exp_hist(int x, logic rst, logic fl, logic [31:0] lk,
                                           logic uv, logic [31:0] up, logic ut);
    int li = idx(x, lk);
    if (!rst || m_left[x] != 0) return 32'd0;
    if (uv && !fl && idx(x, up) == li) return push(x, mem[x][li], ut);
    return mem[x][li];
  endfunction

  function automatic logic [31:0] exp_ready(int x, logic rst);
    return {31'd0, (rst && m_left[x] == 0)};
  endfunction

  task automatic step(int x, logic rst, logic fl, logic uv, logic [31:0] up, logic ut);
    if (!rst) begin
      m_left[x] = ent[x];
    end else if (m_left[x] != 0) begin
      if (fl) m_left[x] = ent[x];
      else begin
        m_left[x]--;
        if (m_left[x] == 0)
          for (int i = 0; i < ent[x]; i++) mem[x][i] = 0;
      end
    end else if (fl) begin
      m_left[x] = ent[x];
    end else if (uv) begin
      mem[x][idx(x, up)] = push(x, mem[x][idx(x, up)], ut);
    end
  endtask

  always @(posedge clock) begin
    step(0, a_reset, a_flush, a_uv, a_up, a_ut);
    step(1, b_reset, b_flush, b_uv, b_up, b_ut);
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("a_ready", {31'd0, a_ready}, exp_ready(0, a_reset));
      check("a_hist", {22'd0, a_hist}, exp_hist(0, a_reset, a_flush, a_lk, a_uv, a_up, a_ut));
      check("b_ready", {31'd0, b_ready}, exp_ready(1, b_reset));
      check("b_hist", {28'd0, b_hist}, exp_hist(1, b_reset, b_flush, b_lk, b_uv, b_up, b_ut));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clock);
    #1;
  endtask

  // Count negedges with ready low until both units are ready (bounded).
  task automatic count_sweep(output int na, output int nb);
    na = 0;
    nb = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      if (!a_ready) na++;
      if (!b_ready) nb++;
      if (a_ready && b_ready) break;
    end
  endtask

  initial begin
    int na, nb, nz;
    a_reset = 0; a_flush = 0; a_uv = 0; a_ut = 0; a_lk = 0; a_up = 0;
    b_reset = 0; b_flush = 0; b_uv = 0; b_ut = 0; b_lk = 0; b_up = 0;
    tick();
    chk_en = 1'b1;
    tick();
    a_reset = 1; b_reset = 1;
    count_sweep(na, nb);
    check("a_init_sweep", na, 1024);
    check("b_init_sweep", nb, 16);

    // taken, taken, not-taken into pc 1234
    tick(); a_uv = 1; a_up = 1234; a_ut = 1;
    tick(); a_ut = 1;
    tick(); a_ut = 0;
    tick(); a_uv = 0; a_lk = 1234;
    at_neg(); check("a_ttn", a_hist, 10'b0110000000);

    tick(); a_uv = 1; a_up = 5; a_lk = 5; a_ut = 1;
    at_neg(); check("a_fwd", a_hist, 10'b1000000000);
    tick(); a_uv = 0;
    at_neg(); check("a_fwd_written", a_hist, 10'b1000000000);

    tick(); a_uv = 1; a_up = 1234 + 1024; a_ut = 1;
    tick(); a_uv = 0; a_lk = 1234;
    at_neg(); check("a_alias_lo", a_hist, 10'b1011000000);
    tick(); a_lk = 1234 + 1024;
    at_neg(); check("a_alias_hi", a_hist, 10'b1011000000);

    tick(); b_uv = 1; b_up = 32'h10; b_ut = 1;
    tick(); b_uv = 0; b_lk = 32'h11;
    at_neg(); check("b_alias_lsb2", b_hist, 4'b1000);

    // flush with a concurrent update to a live entry
    tick(); a_flush = 1; a_uv = 1; a_up = 1234; a_ut = 1; a_lk = 7;
    tick(); a_flush = 0; a_uv = 0; a_lk = 1234;
    count_sweep(na, nb);
    check("a_flush_sweep", na, 1024);
    nz = 0;
    for (int i = 0; i < 1024; i++) begin
      tick(); a_lk = 32'(i) | ($urandom & 32'hFFFFFC00);
      at_neg(); if (a_hist != 0) nz++;
    end
    check("a_all_zero", nz, 0);

    // reset at sweep cycle 500 with updates hammering during CLEAR
    tick(); a_flush = 1;
    tick(); a_flush = 0;
    for (int i = 0; i < 499; i++) begin
      tick(); a_uv = 1'($urandom); a_up = $urandom; a_ut = 1'($urandom);
    end
    tick(); a_reset = 0; a_uv = 1; a_up = 1234; a_ut = 1;
    tick();
    tick(); a_reset = 1;
    count_sweep(na, nb);
    check("a_rst_sweep", na, 1024);
    #1; a_uv = 0; a_lk = 1234;
    tick();
    at_neg(); check("a_rst_no_update", a_hist, 10'd0);

    tick(); b_flush = 1;
    tick(); b_flush = 0;
    for (int i = 0; i < 7; i++) begin
      tick(); b_uv = 1'($urandom); b_up = $urandom; b_ut = 1'($urandom);
    end
    tick(); b_reset = 0; b_uv = 1; b_up = 32'h10; b_ut = 1;
    tick();
    tick(); b_reset = 1;
    count_sweep(na, nb);
    check("b_rst_sweep", nb, 16);
    #1; b_uv = 0; b_lk = 32'h10;
    tick();
    at_neg(); check("b_rst_no_update", b_hist, 4'd0);

    // randomized traffic on a small index set to force hits and aliases
    for (int i = 0; i < 4000; i++) begin
      tick();
      a_reset = ($urandom_range(0, 999) != 0);
      a_flush = a_ready && ($urandom_range(0, 1999) == 0);
      a_uv    = a_flush ? 1'b0 : 1'($urandom);
      a_up    = $urandom & 32'hFFFFFC07;
      a_lk    = $urandom & 32'hFFFFFC07;
      a_ut    = 1'($urandom);
      b_reset = ($urandom_range(0, 699) != 0);
      b_flush = ($urandom_range(0, 299) == 0);
      b_uv    = b_flush ? 1'b0 : 1'($urandom);
      b_up    = $urandom & 32'hFFFFFFCF;
      b_lk    = $urandom & 32'hFFFFFFCF;
      b_ut    = 1'($urandom);
    end
    tick();
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
